wb_ram_slave: RTL and testbench

- Wishbone B3 slave (responder) backing on-chip RAM; the other end of the ParaNut Wishbone master port.
- Serves classic single cycles and registered-feedback incrementing/wrapping bursts (cti_i/bte_i), with byte-lane writes.
- Flags accesses outside its window with err_o.
- Used as boot/scratch memory on the system bus and as the bench responder for the core's bus master.

---
 rtl/wb_ram_slave_if.sv | 37 +++
 rtl/wb_ram_slave.sv | 158 +++++++++++++++
 tb/tb_wb_ram_slave.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_ram_slave_if.sv
// wb_ram_slave_if
//   Wishbone B3 bus bundle between a bus master and the RAM slave.
//   Ports / signals:
//     cyc, stb, we   : cycle valid, transfer strobe, write enable (master -> slave)
//     adr            : byte address (master -> slave)
//     sel            : byte lane enables, bit n covers data[8n+7:8n] (master -> slave)
//     dat_w          : write data (master -> slave)
//     cti, bte       : cycle type / burst type tags (master -> slave)
//     dat_r          : read data, valid while ack is high (slave -> master)
//     ack, err, rty  : transfer terminations (slave -> master)
interface wb_ram_slave_if #(
    parameter int dw = 32,
    parameter int aw = 32
);
    logic          cyc;
    logic          stb;
    logic          we;
    logic [aw-1:0] adr;
    logic [3:0]    sel;
    logic [dw-1:0] dat_w;
    logic [2:0]    cti;
    logic [1:0]    bte;
    logic [dw-1:0] dat_r;
    logic          ack;
    logic          err;
    logic          rty;

    modport master (
        output cyc, stb, we, adr, sel, dat_w, cti, bte,
        input  dat_r, ack, err, rty
    );

    modport slave (
        input  cyc, stb, we, adr, sel, dat_w, cti, bte,
        output dat_r, ack, err, rty
    );
endinterface

// File: rtl/wb_ram_slave.sv
// wb_ram_slave
//   Wishbone B3 slave backed by on-chip RAM. Serves classic single cycles
//   (one wait state) and registered-feedback incrementing / wrapping bursts
//   (one beat per cycle), with byte-lane writes. Accesses outside the
//   address window terminate with err and never touch the RAM.
//   Ports:
//     clk_i : clock, all logic on the rising edge
//     rst_i : synchronous active-high reset (RAM contents are kept)
//     wb    : Wishbone slave modport (cyc/stb/we/adr/sel/dat_w/cti/bte in,
//             dat_r/ack/err/rty out; rty is tied low)
module wb_ram_slave #(
    parameter int            dw             = 32,
    parameter int            aw             = 32,
    parameter int            MEM_WORDS_LOG2 = 10,
    parameter logic [aw-1:0] BASE_ADR       = '0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    wb_ram_slave_if.slave wb
);
    localparam int            IW       = MEM_WORDS_LOG2;
    localparam int            DEPTH    = 1 << IW;
    localparam logic [IW-1:0] IDX_ONE  = 1;
    localparam logic [2:0]    CTI_INCR = 3'b010;
    localparam logic [2:0]    CTI_EOB  = 3'b111;

    typedef enum logic {
        ST_IDLE,
        ST_BURST
    } state_t;

    state_t        state_q, state_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic [dw-1:0] dat_q, dat_d;
    logic [IW-1:0] pred_q, pred_d;
    logic [IW-1:0] addr_q, addr_d;

    logic [dw-1:0] mem [DEPTH];

    logic          req;
    logic          in_range;
    logic          wr_en;
    logic [IW-1:0] adr_idx;
    logic [1:0]    unused_adr_lsb;

    assign req            = wb.cyc & wb.stb;
    assign in_range       = (wb.adr[aw-1:IW+2] == BASE_ADR[aw-1:IW+2]);
    assign adr_idx        = wb.adr[IW+1:2];
    assign unused_adr_lsb = wb.adr[1:0];

    // A write lands on the edge where the master sees our ack; addr_q holds
    // the word of the beat being acked. A reset on that same edge drops it.
    assign wr_en = req & wb.we & ack_q & ~rst_i;

    // Next word of a burst: linear bursts roll over the whole RAM, wrapping
    // bursts only step the low 2/3/4 index bits and keep the rest.
    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx,
                                               input logic [1:0]    bte);
        logic [IW-1:0] inc;
        inc = idx + IDX_ONE;
        case (bte)
            2'b01:   next_idx = {idx[IW-1:2], inc[1:0]};
            2'b10:   next_idx = {idx[IW-1:3], inc[2:0]};
            2'b11:   next_idx = {idx[IW-1:4], inc[3:0]};
            default: next_idx = inc;
        endcase
    endfunction

    // Response and burst sequencing. In BURST the slave has already put the
    // current beat on the bus; while the master keeps requesting with a
    // non-final tag the predicted word is fetched for the following cycle.
    // Reads issued here never collide with the write of the same edge:
    // a granted first access needs ack low, and the prefetched word always
    // differs from the word being written.
    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        dat_d   = '0;
        addr_d  = addr_q;
        pred_d  = pred_q;

        case (state_q)
            ST_IDLE: begin
                if (req && !ack_q && !err_q) begin
                    if (in_range) begin
                        ack_d  = 1'b1;
                        addr_d = adr_idx;
                        if (!wb.we) begin
                            dat_d = mem[adr_idx];
                        end
                        if (wb.cti == CTI_INCR) begin
                            state_d = ST_BURST;
                            pred_d  = next_idx(adr_idx, wb.bte);
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            ST_BURST: begin
                state_d = ST_IDLE;
                if (req && ack_q && wb.cti != CTI_EOB) begin
                    if (in_range) begin
                        state_d = ST_BURST;
                        ack_d   = 1'b1;
                        addr_d  = pred_q;
                        pred_d  = next_idx(pred_q, wb.bte);
                        if (!wb.we) begin
                            dat_d = mem[pred_q];
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
            pred_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
            pred_q  <= pred_d;
            addr_q  <= addr_d;
        end
    end

    // RAM write port with per-byte lane enables; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wb.sel[b]) begin
                    mem[addr_q][8*b +: 8] <= wb.dat_w[8*b +: 8];
                end
            end
        end
    end

    assign wb.dat_r = dat_q;
    assign wb.ack   = ack_q;
    assign wb.err   = err_q;
    assign wb.rty   = 1'b0;
endmodule

// File: tb/tb_wb_ram_slave.sv
// tb_wb_ram_slave
//   Self-checking bench for wb_ram_slave. A transaction-level master drives
//   classic cycles and bursts; a word-array model of the RAM plus the bus
//   timing rules (first response one cycle after the request, then one
//   beat per cycle) give the expected ack/err/data for every cycle, which a
//   single compare process checks on the falling edge.
module tb_wb_ram_slave;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst;

    wb_ram_slave_if bus ();

    wb_ram_slave #(
        .dw(32),
        .aw(32),
        .MEM_WORDS_LOG2(10),
        .BASE_ADR(BASE)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .wb(bus)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    logic [31:0] model_mem [0:1023];
    logic [31:0] wbuf [0:1023];
    logic [31:0] rd_log [$];

    bit          armed = 1'b0;
    bit          exp_ack, exp_err, exp_dchk;
    logic [31:0] exp_dat;
    logic        prev_cyc = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act === want) passes++;
        else $display("[TB] FAIL %s: got %h, want %h (t=%0t)", name, act, want, $time);
    endtask

    task automatic setExp(input bit a, input bit e, input bit dchk, input logic [31:0] d);
        exp_ack  = a;
        exp_err  = e;
        exp_dchk = dchk;
        exp_dat  = d;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Word address of beat b of a burst starting at adr0.
    function automatic int beatWord(input logic [31:0] adr0, input logic [1:0] bte, input int b);
        int w0;
        int len;
        int base;
        w0 = int'(adr0[11:2]);
        if (bte == 2'b00) return (w0 + b) % 1024;
        len  = 2 << bte;
        base = w0 - (w0 % len);
        return base + ((w0 % len) + b) % len;
    endfunction

    task automatic modelWrite(input int w, input logic [31:0] d, input logic [3:0] sel);
        for (int i = 0; i < 4; i++)
            if (sel[i]) model_mem[w][8*i +: 8] = d[8*i +: 8];
    endtask

    task automatic presentBeat(input bit we, input logic [31:0] adr0, input int n, input logic [1:0] bte,
                               input logic [3:0] sel, input int b, input bit inr);
        logic [31:0] a;
        a = adr0;
        if (inr) begin
            a[11:2] = 10'(beatWord(adr0, bte, b));
            a[1:0]  = 2'($urandom_range(0, 3));
        end
        bus.cyc   = 1'b1;
        bus.stb   = 1'b1;
        bus.we    = we;
        bus.adr   = a;
        bus.sel   = sel;
        bus.bte   = bte;
        bus.dat_w = wbuf[b];
        if (n == 1) bus.cti = ($urandom_range(0, 1) == 1) ? 3'b000 : 3'b011;
        else        bus.cti = (b == n - 1) ? 3'b111 : 3'b010;
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            nextCycle();
            bus.cyc = 1'b0;
            bus.stb = 1'b0;
            bus.we  = 1'b0;
            bus.cti = 3'b000;
            setExp(1'b0, 1'b0, 1'b0, '0);
        end
    endtask

    // One transaction of n beats (n=1: classic). stall_at>0 pauses the
    // master for two cycles once that many beats are done; the slave has
    // already prefetched one more beat, so ack stays up for one stalled cycle.
    task automatic applyStimulus(input bit we, input logic [31:0] adr0, input int n, input logic [1:0] bte,
                                 input logic [3:0] sel, input int stall_at);
        int b;
        int w;
        bit inr;
        inr = (adr0[31:12] == BASE[31:12]);
        b = 0;
        while (b < n) begin
            nextCycle();
            presentBeat(we, adr0, n, bte, sel, b, inr);
            setExp(1'b0, 1'b0, 1'b0, '0);
            do begin
                nextCycle();
                presentBeat(we, adr0, n, bte, sel, b, inr);
                if (!inr) begin
                    setExp(1'b0, 1'b1, 1'b1, '0);
                    b = n;
                end else begin
                    w = beatWord(adr0, bte, b);
                    if (we) begin
                        setExp(1'b1, 1'b0, 1'b0, '0);
                        modelWrite(w, wbuf[b], sel);
                    end else begin
                        setExp(1'b1, 1'b0, 1'b1, model_mem[w]);
                    end
                    @(negedge clk);
                    if (!we) rd_log.push_back(bus.dat_r);
                    b++;
                end
            end while (b < n && b != stall_at);
            if (b < n) begin
                nextCycle();
                bus.stb = 1'b0;
                setExp(1'b1, 1'b0, 1'b0, '0);
                nextCycle();
                setExp(1'b0, 1'b0, 1'b0, '0);
            end
        end
    endtask

    always @(posedge clk) prev_cyc <= bus.cyc;

    // Single compare process: every cycle once reset has been applied.
    always @(negedge clk) begin
        if (armed) begin
            checkOutput("ack", 32'(bus.ack), 32'(exp_ack));
            checkOutput("err", 32'(bus.err), 32'(exp_err));
            if (exp_dchk) checkOutput("dat", bus.dat_r, exp_dat);
            checkOutput("rty", 32'(bus.rty), 32'd0);
            checkOutput("ack_err_excl", 32'(bus.ack & bus.err), 32'd0);
            if (!prev_cyc) checkOutput("resp_without_cyc", 32'({bus.ack, bus.err}), 32'd0);
        end
    end

    initial begin
        logic [31:0] t4_exp [4];
        bit          we;
        int          n;
        int          stall;
        logic [1:0]  bte;
        logic [31:0] adr;

        rst       = 1'b1;
        bus.cyc   = 1'b0;
        bus.stb   = 1'b0;
        bus.we    = 1'b0;
        bus.adr   = '0;
        bus.sel   = '0;
        bus.dat_w = '0;
        bus.cti   = '0;
        bus.bte   = '0;
        setExp(1'b0, 1'b0, 1'b1, '0);
        repeat (3) @(posedge clk);
        #1;
        armed = 1'b1;
        nextCycle();
        rst = 1'b0;
        setExp(1'b0, 1'b0, 1'b1, '0);
        idle(1);

        // Fill the whole RAM with one linear burst that rolls over the top.
        for (int i = 0; i < 1024; i++) wbuf[i] = $urandom;
        applyStimulus(1'b1, 32'h800, 1024, 2'b00, 4'hF, 0);
        idle(1);

        $display("[TB] classic write / read");
        wbuf[0] = 32'hDEADBEEF;
        applyStimulus(1'b1, 32'h10, 1, 2'b00, 4'hF, 0);
        idle(1);
        rd_log.delete();
        applyStimulus(1'b0, 32'h10, 1, 2'b00, 4'hF, 0);
        checkOutput("t1_read", rd_log[0], 32'hDEADBEEF);

        $display("[TB] byte lanes, back-to-back classic");
        wbuf[0] = 32'h11223344;
        applyStimulus(1'b1, 32'h20, 1, 2'b00, 4'hF, 0);
        wbuf[0] = 32'hAABBCCDD;
        applyStimulus(1'b1, 32'h20, 1, 2'b00, 4'b0101, 0);
        rd_log.delete();
        applyStimulus(1'b0, 32'h20, 1, 2'b00, 4'hF, 0);
        checkOutput("t2_model", model_mem[8], 32'h11BB33DD);
        checkOutput("t2_read", rd_log[0], 32'h11BB33DD);
        idle(1);

        $display("[TB] linear and wrap-4 bursts");
        for (int k = 0; k < 16; k++) wbuf[k] = k;
        applyStimulus(1'b1, 32'h100, 16, 2'b00, 4'hF, 0);
        idle(1);
        rd_log.delete();
        applyStimulus(1'b0, 32'h100, 4, 2'b00, 4'hF, 0);
        for (int k = 0; k < 4; k++) checkOutput("t3_beat", rd_log[k], k);
        idle(1);
        checkOutput("t4_wrap_adr", 32'(beatWord(32'h108, 2'b01, 2) * 4), 32'h100);
        t4_exp = '{32'd2, 32'd3, 32'd0, 32'd1};
        rd_log.delete();
        applyStimulus(1'b0, 32'h108, 4, 2'b01, 4'hF, 0);
        for (int k = 0; k < 4; k++) checkOutput("t4_beat", rd_log[k], t4_exp[k]);
        idle(1);

        $display("[TB] out-of-window accesses");
        wbuf[0] = 32'h0BADF00D;
        applyStimulus(1'b1, 32'h0, 1, 2'b00, 4'hF, 0);
        applyStimulus(1'b0, 32'h1000, 1, 2'b00, 4'hF, 0);
        wbuf[0] = 32'hFFFFFFFF;
        applyStimulus(1'b1, 32'h1000, 1, 2'b00, 4'hF, 0);
        rd_log.delete();
        applyStimulus(1'b0, 32'h0, 1, 2'b00, 4'hF, 0);
        checkOutput("t5_alias", rd_log[0], 32'h0BADF00D);
        idle(1);

        $display("[TB] master stall mid-burst");
        rd_log.delete();
        applyStimulus(1'b0, 32'h100, 8, 2'b00, 4'hF, 2);
        for (int k = 0; k < 8; k++) checkOutput("t6_stall_beat", rd_log[k], k);
        idle(1);

        $display("[TB] reset mid-burst");
        for (int k = 0; k < 4; k++) wbuf[k] = 32'hC0DE0000 + k;
        applyStimulus(1'b1, 32'h200, 4, 2'b00, 4'hF, 0);
        idle(1);
        nextCycle();
        presentBeat(1'b0, 32'h200, 8, 2'b00, 4'hF, 0, 1'b1);
        setExp(1'b0, 1'b0, 1'b0, '0);
        for (int k = 0; k < 3; k++) begin
            nextCycle();
            presentBeat(1'b0, 32'h200, 8, 2'b00, 4'hF, k, 1'b1);
            setExp(1'b1, 1'b0, 1'b1, model_mem[128 + k]);
        end
        nextCycle();
        presentBeat(1'b0, 32'h200, 8, 2'b00, 4'hF, 3, 1'b1);
        rst = 1'b1;
        setExp(1'b1, 1'b0, 1'b1, model_mem[131]);
        nextCycle();
        rst     = 1'b0;
        bus.cyc = 1'b0;
        bus.stb = 1'b0;
        setExp(1'b0, 1'b0, 1'b1, '0);
        idle(1);
        rd_log.delete();
        applyStimulus(1'b0, 32'h200, 4, 2'b00, 4'hF, 0);
        for (int k = 0; k < 4; k++) checkOutput("t6_after_reset", rd_log[k], 32'hC0DE0000 + k);
        idle(1);

        $display("[TB] random traffic");
        for (int t = 0; t < 150; t++) begin
            we = 1'($urandom_range(0, 1));
            for (int k = 0; k < 20; k++) wbuf[k] = $urandom;
            n     = 1;
            stall = 0;
            bte   = 2'($urandom_range(0, 3));
            adr   = BASE + 32'($urandom_range(0, 4095));
            case ($urandom_range(0, 9))
                0: begin
                    adr = $urandom;
                    if (adr[31:12] == BASE[31:12]) adr[31] = ~adr[31];
                end
                1, 2, 3: n = 1;
                default: begin
                    n = $urandom_range(2, 20);
                    if ($urandom_range(0, 3) == 0) stall = $urandom_range(1, n - 1);
                end
            endcase
            applyStimulus(we, adr, n, bte, 4'($urandom), stall);
            idle($urandom_range(0, 2));
        end

        idle(2);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
